// File: rtl/decoder_scan_ctrl.sv
// Row-scan controller for a 3-to-8 decoder (74x138 style enables).
// Each selected row gets a blanking gap with the decoder disabled, then a dwell with it enabled.
module decoder_scan_ctrl #(
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       mode_cont,
    input  logic [7:0] dwell,
    input  logic [7:0] row_mask,
    output logic       E1_n,
    output logic       E2_n,
    output logic       E3,
    output logic       A2,
    output logic       A1,
    output logic       A0,
    output logic       busy,
    output logic       frame_done
);

    localparam int BLK = (BLANK_CYC < 1) ? 1 : BLANK_CYC;
    localparam int BW  = $clog2(BLK + 1);
    localparam int CW  = (BW > 8) ? BW : 8;
    localparam logic [CW-1:0] BLK_LAST = CW'(BLK - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      row_q, row_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      dwell_q, dwell_d;
    logic [7:0]      mask_q, mask_d;
    logic            cont_q, cont_d;
    logic            e1_n_q, e1_n_d;
    logic            e2_n_q, e2_n_d;
    logic            e3_q, e3_d;
    logic            busy_q, busy_d;
    logic            fd_q, fd_d;
    logic            en_d;

    logic [2:0]      nxt_row;
    logic            has_nxt;

    function automatic logic [2:0] lowest_set(input logic [7:0] m);
        logic [2:0] r;
        r = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) r = 3'(i);
        end
        return r;
    endfunction

    // Next selected row strictly above the current one, if any.
    always_comb begin
        nxt_row = '0;
        has_nxt = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i] && (3'(i) > row_q)) begin
                nxt_row = 3'(i);
                has_nxt = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        fd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    dwell_d = (dwell == 8'd0) ? 8'd1 : dwell;
                    mask_d  = row_mask;
                    cont_d  = mode_cont;
                    if (row_mask != 8'd0) begin
                        state_d = BLANK;
                        row_d   = lowest_set(row_mask);
                        cnt_d   = BLK_LAST;
                    end else begin
                        fd_d = 1'b1;
                    end
                end
            end
            BLANK: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = DRIVE;
                    cnt_d   = CW'(dwell_q) - CW'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DRIVE: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (has_nxt) begin
                    state_d = BLANK;
                    row_d   = nxt_row;
                    cnt_d   = BLK_LAST;
                end else begin
                    // Frame end: the address holds in IDLE, wraps in continuous mode.
                    fd_d = 1'b1;
                    if (cont_q) begin
                        state_d = BLANK;
                        row_d   = lowest_set(mask_q);
                        cnt_d   = BLK_LAST;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        en_d   = (state_d == DRIVE);
        busy_d = (state_d != IDLE);
        e1_n_d = ~en_d;
        e2_n_d = ~en_d;
        e3_d   = en_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= '0;
            cont_q  <= 1'b0;
            e1_n_q  <= 1'b1;
            e2_n_q  <= 1'b1;
            e3_q    <= 1'b0;
            busy_q  <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
            e1_n_q  <= e1_n_d;
            e2_n_q  <= e2_n_d;
            e3_q    <= e3_d;
            busy_q  <= busy_d;
            fd_q    <= fd_d;
        end
    end

    assign E1_n         = e1_n_q;
    assign E2_n         = e2_n_q;
    assign E3           = e3_q;
    assign {A2, A1, A0} = row_q;
    assign busy         = busy_q;
    assign frame_done   = fd_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl: a per-cycle vector table for short cases,
// plus hand-written sequences for full frames, continuous mode, stop and reset.
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       mode_cont = 1'b0;
    logic [7:0] dwell = 8'd0;
    logic [7:0] row_mask = 8'd0;
    logic       E1_n, E2_n, E3, A2, A1, A0, busy, frame_done;

    int total = 0;
    int bad   = 0;

    decoder_scan_ctrl #(.BLANK_CYC(2)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode_cont(mode_cont),
        .dwell(dwell), .row_mask(row_mask),
        .E1_n(E1_n), .E2_n(E2_n), .E3(E3), .A2(A2), .A1(A1), .A0(A0),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, start, stop, cont;
        logic [7:0] dwell, mask;
        logic       e_en;
        logic [2:0] e_addr;
        logic       e_busy, e_fd;
    } vec_t;

    vec_t vt[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic en, input logic [2:0] a,
                       input logic b, input logic f);
        logic [7:0] got, exp;
        got = {E1_n, E2_n, E3, A2, A1, A0, busy, frame_done};
        exp = {~en, ~en, en, a, b, f};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {E1_n,E2_n,E3,A,busy,fd}=%b want=%b", nm, got, exp);
        end
    endtask

    initial begin
        // rst, start, stop, cont, dwell, mask | en, addr, busy, fd
        vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd3, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd3, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'd3, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd5, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd5, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h10, 1'b0, 3'd4, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd9, 8'hFF, 1'b0, 3'd4, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 8'h01, 1'b1, 3'd4, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'h01, 1'b0, 3'd4, 1'b0, 1'b1};
        vt[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd7, 8'h01, 1'b0, 3'd4, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            rst = vt[i].rst; start = vt[i].start; stop = vt[i].stop;
            mode_cont = vt[i].cont; dwell = vt[i].dwell; row_mask = vt[i].mask;
            tick();
            chk($sformatf("vec%0d", i), vt[i].e_en, vt[i].e_addr, vt[i].e_busy, vt[i].e_fd);
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0;

        // Full single frame, all rows, dwell 3: 5 cycles per row, frame_done at cycle 41.
        row_mask = 8'hFF; dwell = 8'd3; mode_cont = 1'b0; start = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            if (c <= 40)
                chk($sformatf("frame_c%0d", c), ((c - 1) % 5) >= 2, 3'((c - 1) / 5), 1'b1, 1'b0);
            else if (c == 41)
                chk("frame_done", 1'b0, 3'd7, 1'b0, 1'b1);
            else
                chk("frame_idle", 1'b0, 3'd7, 1'b0, 1'b0);
        end

        // Continuous mode, rows 0,2,7 with dwell 1: 3 cycles per row.
        row_mask = 8'b1000_0101; dwell = 8'd1; mode_cont = 1'b1; start = 1'b1;
        for (int t = 0; t < 27; t++) begin
            int k, p;
            logic [2:0] r;
            tick();
            if (t == 0) start = 1'b0;
            k = (t % 9) / 3;
            p = t % 3;
            r = (k == 0) ? 3'd0 : (k == 1) ? 3'd2 : 3'd7;
            chk($sformatf("cont_t%0d", t), p == 2, r, 1'b1, (p == 0) && (k == 0) && (t >= 9));
        end
        // Stop lands on the frame-end edge and must suppress frame_done.
        stop = 1'b1;
        tick();
        chk("stop_at_frame_end", 1'b0, 3'd7, 1'b0, 1'b0);
        stop = 1'b0;

        // Stop in the second DRIVE cycle of row 4 (cycle 24 of an all-rows frame).
        row_mask = 8'hFF; dwell = 8'd3; mode_cont = 1'b0; start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            chk($sformatf("pre_stop_c%0d", c), ((c - 1) % 5) >= 2, 3'((c - 1) / 5), 1'b1, 1'b0);
        end
        stop = 1'b1;
        tick();
        chk("stop_drive", 1'b0, 3'd4, 1'b0, 1'b0);
        stop = 1'b0;
        tick();
        chk("stop_idle", 1'b0, 3'd4, 1'b0, 1'b0);

        // Restart goes back to the lowest set row.
        start = 1'b1;
        tick();
        chk("restart_blank", 1'b0, 3'd0, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        chk("restart_blank2", 1'b0, 3'd0, 1'b1, 1'b0);
        tick();
        chk("restart_drive", 1'b1, 3'd0, 1'b1, 1'b0);

        // Reset in the middle of DRIVE.
        rst = 1'b1;
        tick();
        chk("rst_mid_drive", 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk("after_rst", 1'b0, 3'd0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
